drisc_bus_bridge: RTL and testbench

// - Sits directly downstream of the drisc core's external pads (io_bus, address_bus, data_size, write_address, read, write).
// - Converts the core's address-latch/read/write strobes into a req/ack memory transaction with byte enables.
// - Buffers read data and drives it back onto io_bus. Flags misaligned, unmapped and timed-out accesses.

---
 rtl/drisc_bus_bridge.sv | 195 +++++++++++++++++++
 tb/tb_drisc_bus_bridge.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drisc_bus_bridge.sv
// drisc_bus_bridge
//   Turns the drisc core's pad-level strobes (write_address / read / write)
//   into a single outstanding req/ack memory transaction with byte enables.
//   Read data is buffered and driven back onto the shared io_bus. Misaligned,
//   unmapped, timed-out and read+write-together accesses raise a sticky
//   bus_error, and err_addr records the first faulting address.
//
// Ports
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   io_bus             bidirectional core data bus (driven while io_drive=1)
//   address_bus        core byte address, latched on write_address
//   data_size          0=byte 1=half 2=word 3=illegal, latched on write_address
//   write_address      address/size latch strobe
//   read, write        core access strobes, held until the access completes
//   stall              high while a memory request is outstanding
//   bus_error          sticky error flag, err_clear clears it
//   err_clear          clears bus_error and err_addr (a new error wins)
//   err_addr           address of the first faulting access
//   mem_req .. mem_be  memory request side, held stable until mem_ack
//   mem_rdata, mem_ack memory completion side
//   io_drive           high while the bridge is driving io_bus
//   state_dbg          current FSM state (IDLE=0 BUSY=1 DONE=2 ERROR=3)
//
// Handshake: mem_req rises with mem_we/mem_addr/mem_be/mem_wdata stable and
// they all stay stable until the cycle mem_ack is sampled high; mem_ack is a
// one-cycle pulse and is ignored whenever no request is outstanding.

module drisc_bus_bridge #(
    parameter logic [31:0] RAM_BASE     = 32'h0000_0000,
    parameter int          RAM_SIZE_LOG = 16,
    parameter int          TIMEOUT      = 15
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [31:0] io_bus,
    input  logic [31:0] address_bus,
    input  logic [1:0]  data_size,
    input  logic        write_address,
    input  logic        read,
    input  logic        write,
    output logic        stall,
    output logic        bus_error,
    input  logic        err_clear,
    output logic [31:0] err_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        io_drive,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] lat_addr;
    logic [1:0]  lat_size;
    logic        addr_valid;
    logic [31:0] rbuf;
    logic        buf_valid;
    logic [7:0]  cnt;

    logic        strobe;
    logic [3:0]  be_calc;
    logic        misaligned;
    logic [32:0] offset;
    logic        in_range;
    logic        fault;

    assign strobe = read | write;

    always_comb begin
        be_calc    = 4'b0000;
        misaligned = 1'b0;
        case (lat_size)
            2'd0: be_calc = 4'b0001 << lat_addr[1:0];
            2'd1: begin
                be_calc    = lat_addr[1] ? 4'b1100 : 4'b0011;
                misaligned = lat_addr[0];
            end
            2'd2: begin
                be_calc    = 4'b1111;
                misaligned = (lat_addr[1:0] != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Bit 32 of the offset is the borrow, i.e. lat_addr below RAM_BASE.
    assign offset   = {1'b0, lat_addr} - {1'b0, RAM_BASE};
    assign in_range = !offset[32] && ((offset[31:0] >> RAM_SIZE_LOG) == 32'd0);
    assign fault    = misaligned | ~in_range;

    // The buffer is served both right after completion and on later reads
    // in IDLE, until a new address is latched.
    assign io_drive  = read & buf_valid & ((state == DONE) | (state == IDLE));
    assign io_bus    = io_drive ? rbuf : 32'bz;
    assign state_dbg = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_addr   <= 32'd0;
            lat_size   <= 2'd0;
            addr_valid <= 1'b0;
            rbuf       <= 32'd0;
            buf_valid  <= 1'b0;
            cnt        <= 8'd0;
            stall      <= 1'b0;
            bus_error  <= 1'b0;
            err_addr   <= 32'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 30'd0;
            mem_be     <= 4'd0;
            mem_wdata  <= 32'd0;
        end else begin
            // Clear first so that any error raised below in the same cycle wins.
            if (err_clear) begin
                bus_error <= 1'b0;
                err_addr  <= 32'd0;
            end

            case (state)
                IDLE: begin
                    if (strobe && addr_valid) begin
                        // Each latched address launches at most one access.
                        addr_valid <= 1'b0;
                        if (read && write) begin
                            bus_error <= 1'b1;
                            if (!bus_error || err_clear) err_addr <= lat_addr;
                        end
                        if (fault) begin
                            state <= ERROR;
                        end else begin
                            state     <= BUSY;
                            mem_req   <= 1'b1;
                            stall     <= 1'b1;
                            mem_we    <= write;
                            mem_addr  <= lat_addr[31:2];
                            mem_be    <= be_calc;
                            mem_wdata <= io_bus;
                            cnt       <= 8'd0;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 8'd1;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        stall   <= 1'b0;
                        state   <= DONE;
                        if (!mem_we) begin
                            rbuf      <= mem_rdata;
                            buf_valid <= 1'b1;
                        end
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        // cnt counts completed BUSY cycles, so mem_req has been
                        // high for exactly TIMEOUT cycles when it drops here.
                        mem_req <= 1'b0;
                        stall   <= 1'b0;
                        state   <= ERROR;
                    end
                end
                DONE: begin
                    if (!read && !write) state <= IDLE;
                end
                ERROR: begin
                    bus_error <= 1'b1;
                    if (!bus_error || err_clear) err_addr <= lat_addr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A new address also retires the read buffer; ignored in BUSY so
            // the outstanding access keeps its address and size.
            if (write_address && state != BUSY) begin
                lat_addr   <= address_bus;
                lat_size   <= data_size;
                addr_valid <= 1'b1;
                buf_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_drisc_bus_bridge.sv
// Bench for drisc_bus_bridge: directed accesses, a transaction-level
// expectation model and a per-cycle compare on the falling edge.
module tb_drisc_bus_bridge;

    localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
    localparam int          RAM_SIZE_LOG = 16;
    localparam int          TIMEOUT      = 15;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // DUT connections
    wire  [31:0] io_bus;
    logic [31:0] address_bus   = '0;
    logic [1:0]  data_size     = '0;
    logic        write_address = 1'b0;
    logic        read          = 1'b0;
    logic        write         = 1'b0;
    logic        stall;
    logic        bus_error;
    logic        err_clear     = 1'b0;
    logic [31:0] err_addr;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata     = '0;
    logic        mem_ack       = 1'b0;
    logic        io_drive;
    logic [1:0]  state_dbg;

    logic        tb_oe = 1'b0;
    logic [31:0] tb_io = '0;
    assign io_bus = tb_oe ? tb_io : 32'bz;

    drisc_bus_bridge #(
        .RAM_BASE(RAM_BASE), .RAM_SIZE_LOG(RAM_SIZE_LOG), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .io_bus(io_bus),
        .address_bus(address_bus), .data_size(data_size),
        .write_address(write_address), .read(read), .write(write),
        .stall(stall), .bus_error(bus_error), .err_clear(err_clear),
        .err_addr(err_addr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .io_drive(io_drive),
        .state_dbg(state_dbg)
    );

    // counters
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // expectation model (what the outputs must be after the latest edge)
    bit          chk_on       = 1'b0;
    logic        exp_req      = 1'b0;
    logic        exp_stall    = 1'b0;
    logic        exp_we       = 1'b0;
    logic [29:0] exp_addr     = '0;
    logic [3:0]  exp_be       = '0;
    logic [31:0] exp_wdata    = '0;
    logic        exp_err      = 1'b0;
    logic [31:0] exp_err_addr = '0;
    logic        exp_drive    = 1'b0;
    logic [31:0] exp_io       = '0;
    logic [31:0] m_buf        = '0;
    bit          m_buf_valid  = 1'b0;
    int          req_hi_cnt   = 0;

    function automatic bit m_fault(input logic [31:0] a, input logic [1:0] s);
        longint ua  = longint'(a);
        longint lo  = longint'(RAM_BASE);
        longint lim = lo + (longint'(1) << RAM_SIZE_LOG);
        if (s == 2'd3) return 1'b1;
        if (s == 2'd1 && (a % 2) != 0) return 1'b1;
        if (s == 2'd2 && (a % 4) != 0) return 1'b1;
        return (ua < lo) || (ua >= lim);
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'd0) return 4'(1 << (a % 4));
        if (s == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    task automatic flag_error(input logic [31:0] a);
        if (!exp_err) exp_err_addr = a;
        exp_err = 1'b1;
    endtask

    // single compare process
    always @(negedge clock) begin
        if (chk_on) begin
            if (mem_req === 1'b1) req_hi_cnt++;
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("bus_error", 32'(bus_error), 32'(exp_err));
            chk("err_addr", err_addr, exp_err_addr);
            chk("io_drive", 32'(io_drive), 32'(exp_drive));
            if (exp_req) begin
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
                chk("mem_be", 32'(mem_be), 32'(exp_be));
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            end
            if (exp_drive) chk("io_bus", io_bus, exp_io);
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // ack_at: the mem_req-high cycle (1-based) in which mem_ack pulses; 0 = never.
    task automatic access(input logic [31:0] addr, input logic [1:0] size,
                          input bit wr, input bit rd, input logic [31:0] wdata,
                          input int ack_at, input logic [31:0] rdata,
                          output logic [31:0] rd_seen);
        bit   flt;
        bit   acked;
        flt     = m_fault(addr, size);
        acked   = 1'b0;
        rd_seen = '0;

        address_bus   = addr;
        data_size     = size;
        write_address = 1'b1;
        cyc();
        write_address = 1'b0;
        m_buf_valid   = 1'b0;

        write = wr;
        read  = rd;
        if (wr) begin
            tb_oe = 1'b1;
            tb_io = wdata;
        end
        cyc();
        if (wr && rd) flag_error(addr);
        if (flt) begin
            write = 1'b0; read = 1'b0; tb_oe = 1'b0;
            cyc();
            flag_error(addr);
            return;
        end

        exp_req   = 1'b1;
        exp_stall = 1'b1;
        exp_we    = wr;
        exp_addr  = addr[31:2];
        exp_be    = m_be(addr, size);
        exp_wdata = wdata;
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (k == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            cyc();
            mem_ack = 1'b0;
            if (k == ack_at) begin
                acked     = 1'b1;
                exp_req   = 1'b0;
                exp_stall = 1'b0;
                if (rd && !wr) begin
                    m_buf       = rdata;
                    m_buf_valid = 1'b1;
                    exp_drive   = 1'b1;
                    exp_io      = rdata;
                end
                break;
            end
            if (k == TIMEOUT) begin
                exp_req   = 1'b0;
                exp_stall = 1'b0;
            end
        end

        if (!acked) begin
            write = 1'b0; read = 1'b0; tb_oe = 1'b0;
            cyc();
            flag_error(addr);
            return;
        end

        cyc();
        if (exp_drive) rd_seen = io_bus;
        read = 1'b0; write = 1'b0; tb_oe = 1'b0;
        exp_drive = 1'b0;
        cyc();
    endtask

    // directed sequence
    logic [31:0] seen;

    initial begin
        cyc();
        cyc();
        // reset values with reset still asserted
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_io_drive", 32'(io_drive), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        reset  = 1'b0;
        chk_on = 1'b1;
        cyc();

        // word write, ack in the third request cycle
        access(32'h100, 2'd2, 1'b1, 1'b0, 32'hDEAD_BEEF, 3, 32'h0, seen);
        chk("ww_mem_addr", 32'(mem_addr), 32'h40);
        chk("ww_mem_be", 32'(mem_be), 32'hF);
        chk("ww_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("ww_mem_we", 32'(mem_we), 32'd1);

        // byte read at 0x103 returns the whole word
        access(32'h103, 2'd0, 1'b0, 1'b1, 32'h0, 2, 32'h1122_3344, seen);
        chk("br_mem_be", 32'(mem_be), 32'h8);
        chk("br_io_bus", seen, 32'h1122_3344);
        chk("br_released", 32'(io_drive), 32'd0);

        // the buffer is served again on a read in IDLE until a new latch
        read      = 1'b1;
        exp_drive = 1'b1;
        exp_io    = m_buf;
        cyc();
        address_bus   = 32'h200;
        data_size     = 2'd2;
        write_address = 1'b1;
        cyc();
        write_address = 1'b0;
        read          = 1'b0;
        m_buf_valid   = 1'b0;
        exp_drive     = 1'b0;
        cyc();

        // upper half read
        access(32'h102, 2'd1, 1'b0, 1'b1, 32'h0, 1, 32'hCAFE_F00D, seen);
        chk("hr_io_bus", seen, 32'hCAFE_F00D);

        // misaligned half: no request, error recorded
        req_hi_cnt = 0;
        access(32'h101, 2'd1, 1'b0, 1'b1, 32'h0, 1, 32'h0, seen);
        chk("mis_no_req", 32'(req_hi_cnt), 32'd0);
        chk("mis_bus_error", 32'(bus_error), 32'd1);
        chk("mis_err_addr", err_addr, 32'h101);

        err_clear = 1'b1;
        cyc();
        err_clear    = 1'b0;
        exp_err      = 1'b0;
        exp_err_addr = 32'h0;
        chk("clr_bus_error", 32'(bus_error), 32'd0);
        chk("clr_err_addr", err_addr, 32'd0);

        // first address beyond the mapped region
        req_hi_cnt = 0;
        access(32'h0001_0000, 2'd2, 1'b0, 1'b1, 32'h0, 1, 32'h0, seen);
        chk("unm_no_req", 32'(req_hi_cnt), 32'd0);
        chk("unm_err_addr", err_addr, 32'h0001_0000);

        // no ack: request held for exactly TIMEOUT cycles; err_addr keeps the first fault
        req_hi_cnt = 0;
        access(32'h8, 2'd2, 1'b0, 1'b1, 32'h0, 0, 32'h0, seen);
        chk("to_req_cycles", 32'(req_hi_cnt), 32'd15);
        chk("to_err_addr", err_addr, 32'h0001_0000);

        // illegal size
        access(32'h0, 2'd3, 1'b1, 1'b0, 32'h5555_AAAA, 1, 32'h0, seen);

        err_clear = 1'b1;
        cyc();
        err_clear    = 1'b0;
        exp_err      = 1'b0;
        exp_err_addr = 32'h0;

        // read and write together: the write proceeds and the error is flagged
        access(32'h20, 2'd2, 1'b1, 1'b1, 32'h0BAD_F00D, 1, 32'h7777_7777, seen);
        chk("rw_err_addr", err_addr, 32'h20);
        chk("rw_mem_we", 32'(mem_we), 32'd1);

        err_clear = 1'b1;
        cyc();
        err_clear    = 1'b0;
        exp_err      = 1'b0;
        exp_err_addr = 32'h0;

        // stray ack in IDLE changes nothing
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        cyc();
        mem_ack = 1'b0;
        cyc();

        // reset in the middle of a request
        address_bus   = 32'h300;
        data_size     = 2'd2;
        write_address = 1'b1;
        cyc();
        write_address = 1'b0;
        read          = 1'b1;
        cyc();
        exp_req   = 1'b1;
        exp_stall = 1'b1;
        exp_we    = 1'b0;
        exp_addr  = 30'h0C0;
        exp_be    = 4'hF;
        cyc();
        #3;
        exp_req   = 1'b0;
        exp_stall = 1'b0;
        reset     = 1'b1;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_io_drive", 32'(io_drive), 32'd0);
        chk("arst_state", 32'(state_dbg), 32'd0);
        read = 1'b0;
        cyc();
        reset       = 1'b0;
        m_buf_valid = 1'b0;
        cyc();

        // normal access after reset
        access(32'h40, 2'd2, 1'b0, 1'b1, 32'h0, 4, 32'hA5A5_5A5A, seen);
        chk("post_rst_io_bus", seen, 32'hA5A5_5A5A);
        cyc();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
